cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, input/output sample width (two's complement).
REQ-002 SHALL have parameter STAGES, default 3, number of integrator and comb stages N.
REQ-003 SHALL have parameter R, default 5, integer decimation factor, legal range 2..16.
REQ-004 SHALL have parameter GROWTH, default 7, internal bit growth, equal to ceil(STAGES*log2(R)).
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port x_n  input  DATA_WIDTH  signed sample from the fractional decimator (its y_m).
REQ-008 SHALL have port valid_in  input  1  x_n qualifier, driven by the fractional decimator's valid; any duty cycle, back-to-back allowed.
REQ-009 SHALL have port y_m  output  DATA_WIDTH  signed decimated sample.
REQ-010 SHALL have port valid_out  output  1  one-cycle pulse marking a new y_m.

Function
REQ-011 SHALL implement a CIC decimator with differential delay M=1: STAGES integrators at input rate, decimate by R, STAGES combs at output rate.
REQ-012 SHALL size all integrator and comb registers to W = DATA_WIDTH+GROWTH bits, with x_n sign-extended to W.
REQ-013 SHALL update integrators only on cycles with valid_in=1; with valid_in=0, all integrator state holds.
REQ-014 SHALL let integrators wrap modulo 2^W with no saturation; the comb differences recover the correct result.
REQ-015 SHALL keep a phase counter 0..R-1, advanced once per accepted sample, wrapping R-1 -> 0.
REQ-016 SHALL, when the sample accepted at phase R-1 has updated the last integrator, pass that integrator value to the comb chain.
REQ-017 SHALL have the first decimated output correspond to accepted samples 0..R-1 after reset.
REQ-018 SHALL have each comb stage compute c_out = c_in - c_in_delayed (one-output-sample delay), in modulo-2^W arithmetic, registered one cycle per stage.
REQ-019 SHALL derive the output as (comb_out + 2^(GROWTH-1)) arithmetic-shifted right by GROWTH, keeping the low DATA_WIDTH bits; the DC gain is R^STAGES/2^GROWTH (125/128 by default).
REQ-020 SHALL not saturate the output, since the gain is at most 1 by construction.
REQ-021 SHALL assert valid_out for exactly one cycle, STAGES+1 cycles after the edge that accepted the phase-(R-1) sample.
REQ-022 SHALL hold y_m stable between valid_out pulses.
REQ-023 SHALL support valid_in every cycle, because the comb pipeline is fully pipelined and R>=2 guarantees no output overlap.
REQ-024 SHALL make output values independent of valid_in gap pattern; only timing shifts.

Reset
REQ-025 SHALL, while RST=1, clear integrators, comb registers, comb delays, the phase counter, y_m and valid_out to 0 immediately, without waiting for a clock edge.
REQ-026 SHALL, on RST asserted mid-operation, discard partial decimation phase and pipeline contents, suppress any in-flight valid_out, and restart at phase 0 after release.
REQ-027 SHALL accept the first sample on the first rising edge with RST=0 and valid_in=1.

Verification
REQ-028 SHALL cover reset: RST=1 with x_n toggling -> y_m=0, valid_out=0 throughout; after release, no valid_out before R accepted samples.
REQ-029 SHALL cover DC: x_n=1000 constant, valid_in every cycle -> outputs settle to 977 from the STAGES-th valid_out onward; valid_out once every 5 cycles.
REQ-030 SHALL cover impulse: x_n=128 at the first accepted sample, then 0 -> first three outputs 15, 10, 0, all further outputs 0.
REQ-031 SHALL cover negative full scale and wrap: x_n=-32768 for 10000 samples -> steady output -32000, no deviation after integrators wrap.
REQ-032 SHALL cover cadence: the DC and impulse tests repeated with valid_in every 2nd cycle and with pseudo-random gaps -> identical y_m sequence to the back-to-back run.
REQ-033 SHALL cover mid-operation reset: RST pulsed after 7 accepted samples of DC 1000 -> no stale valid_out; the post-reset sequence matches a fresh DC run.

Source files
------------

// File: rtl/cic_decimator.sv
// CIC decimator: STAGES integrators at input rate, decimate by R,
// STAGES combs (M=1) at output rate, rounded back to DATA_WIDTH.
module cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 3,
  parameter int R          = 5,
  parameter int GROWTH     = 7
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] x_n,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] y_m,
  output logic                  valid_out
);

  localparam int W  = DATA_WIDTH + GROWTH;
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  localparam logic [PW-1:0] LAST = PW'(R - 1);
  localparam logic [W-1:0]  HALF = W'(1) << (GROWTH - 1);

  logic [W-1:0]          x_ext;
  logic [W-1:0]          acc;
  logic [W-1:0]          integ_q [STAGES];
  logic [W-1:0]          integ_d [STAGES];
  logic [PW-1:0]         phase_q;
  logic [PW-1:0]         phase_d;
  logic [STAGES:0]       vld_q;
  logic [STAGES:0]       vld_d;
  logic [W-1:0]          comb_q  [STAGES];
  logic [W-1:0]          comb_d  [STAGES];
  logic [W-1:0]          dly_q   [STAGES];
  logic [W-1:0]          dly_d   [STAGES];
  logic [W-1:0]          rnd;
  logic [DATA_WIDTH-1:0] y_q;
  logic [DATA_WIDTH-1:0] y_d;
  logic                  vout_q;
  logic                  vout_d;

  assign x_ext = {{GROWTH{x_n[DATA_WIDTH-1]}}, x_n};

  // Integrator chain settles in one cycle so the last stage
  // already holds the phase-(R-1) sample at the accepting edge.
  always_comb begin
    acc = x_ext;
    for (int k = 0; k < STAGES; k++) begin
      acc        = integ_q[k] + acc;
      integ_d[k] = valid_in ? acc : integ_q[k];
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (valid_in) begin
      if (phase_q == LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
    vld_d = {vld_q[STAGES-1:0], valid_in && (phase_q == LAST)};
  end

  always_comb begin
    comb_d[0] = comb_q[0];
    dly_d[0]  = dly_q[0];
    if (vld_q[0]) begin
      comb_d[0] = integ_q[STAGES-1] - dly_q[0];
      dly_d[0]  = integ_q[STAGES-1];
    end
    for (int k = 1; k < STAGES; k++) begin
      comb_d[k] = comb_q[k];
      dly_d[k]  = dly_q[k];
      if (vld_q[k]) begin
        comb_d[k] = comb_q[k-1] - dly_q[k];
        dly_d[k]  = comb_q[k-1];
      end
    end
  end

  always_comb begin
    rnd    = comb_q[STAGES-1] + HALF;
    y_d    = y_q;
    vout_d = vld_q[STAGES];
    if (vld_q[STAGES]) begin
      y_d = DATA_WIDTH'(rnd >> GROWTH);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      phase_q <= '0;
      vld_q   <= '0;
      y_q     <= '0;
      vout_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
      phase_q <= phase_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      vout_q  <= vout_d;
    end
  end

  assign y_m       = y_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: equivalent-FIR reference model feeding
// a scoreboard, popped by a monitor on every valid_out pulse.
module tb_cic_decimator;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int R  = 5;
  localparam int G  = 7;
  localparam int HL = N * (R - 1) + 1;

  typedef struct {
    logic signed [DW-1:0] val;
    int                   cyc;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] x_n;
  logic          valid_in;
  logic [DW-1:0] y_m;
  logic          valid_out;

  int     checks;
  int     errors;
  int     cyc;
  int     drain_evt;
  int     drain_seen;
  int     drain_left;
  exp_t   sb[$];
  int     hist[$];
  longint h[HL];
  logic signed [DW-1:0] last_exp;

  cic_decimator #(
    .DATA_WIDTH(DW),
    .STAGES(N),
    .R(R),
    .GROWTH(G)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .x_n(x_n),
    .valid_in(valid_in),
    .y_m(y_m),
    .valid_out(valid_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    longint t[HL];
    int len;
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < HL; i++) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) t[i+j] += h[i];
      len += R - 1;
      for (int i = 0; i < HL; i++) h[i] = t[i];
    end
  endtask

  function automatic logic signed [DW-1:0] model(int m);
    longint v;
    int     ne;
    v  = 0;
    ne = R * m + R - 1;
    for (int j = 0; j < HL; j++)
      if (ne - j >= 0) v += h[j] * longint'(hist[ne-j]);
    v = (v + (longint'(1) << (G - 1))) >>> G;
    return v[DW-1:0];
  endfunction

  function automatic int gap_of(int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic send(input logic signed [DW-1:0] x, input int gap);
    exp_t e;
    for (int i = 0; i < gap; i++) begin
      valid_in = 1'b0;
      x_n      = DW'($urandom);
      @(posedge CLK); #1;
    end
    valid_in = 1'b1;
    x_n      = x;
    hist.push_back(int'(x));
    if (hist.size() % R == 0) begin
      e.val = model(hist.size() / R - 1);
      e.cyc = cyc + N + 2;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    valid_in = 1'b0;
  endtask

  task automatic run(input int kind, input int mode, input int n);
    logic signed [DW-1:0] x;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: x = 16'sd1000;
        1: x = (i == 0) ? 16'sd128 : 16'sd0;
        2: x = -16'sd32768;
        default: x = DW'($urandom);
      endcase
      send(x, gap_of(mode));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      x_n      = DW'($urandom);
      valid_in = 1'($urandom);
      @(posedge CLK); #1;
    end
    RST      = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    repeat (3) @(posedge CLK);
    #1;
    drain_left = sb.size();
    drain_evt  = drain_evt + 1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // Monitor: sole owner of the counters, last_exp and queue pops.
  initial begin
    exp_t e;
    checks     = 0;
    errors     = 0;
    drain_seen = 0;
    last_exp   = '0;
    forever begin
      @(negedge CLK or posedge RST);
      #1;
      if (RST) begin
        sb.delete();
        last_exp = '0;
        checks++;
        if (valid_out !== 1'b0 || y_m !== '0) begin
          errors++;
          $display("FAIL reset_clear y_m=%0d valid_out=%b required 0/0",
                   $signed(y_m), valid_out);
        end
      end else if (valid_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid y_m=%0d cyc=%0d required none",
                   $signed(y_m), cyc);
        end else begin
          e = sb.pop_front();
          last_exp = e.val;
          if (y_m !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL output y_m=%0d cyc=%0d required %0d cyc=%0d",
                     $signed(y_m), cyc, e.val, e.cyc);
          end
        end
      end else begin
        checks++;
        if (valid_out !== 1'b0 || y_m !== last_exp) begin
          errors++;
          $display("FAIL hold y_m=%0d valid_out=%b required %0d/0",
                   $signed(y_m), valid_out, last_exp);
        end
      end
      if (drain_evt != drain_seen) begin
        drain_seen = drain_evt;
        checks++;
        if (drain_left != 0) begin
          errors++;
          $display("FAIL drain pending=%0d required 0", drain_left);
        end
      end
    end
  end

  initial begin
    drain_evt  = 0;
    drain_left = 0;
    RST        = 1'b1;
    valid_in   = 1'b0;
    x_n        = '0;
    build_h();
    @(posedge CLK); #1;
    for (int mode = 0; mode < 3; mode++) begin
      do_reset();
      run(0, mode, 40);
      drain();
      do_reset();
      run(1, mode, 30);
      drain();
    end
    do_reset();
    run(2, 0, 10000);
    drain();
    do_reset();
    run(2, 2, 200);
    drain();
    do_reset();
    run(0, 0, 7);
    do_reset();
    run(0, 0, 40);
    drain();
    do_reset();
    run(3, 2, 300);
    drain();
    do_reset();
    run(3, 0, 300);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
